lc3_regfile_wb: RTL and testbench

Write-back end of the LC-3 datapath bus. The bus source muxes select one 16-bit value onto the bus each cycle. This block is the receiving side. It decodes the destination register and loads the bus value into one of eight general-purpose registers. It also updates the NZP condition codes from the same bus value and registers the branch-enable (BEN) flag for the control FSM. It sits between the datapath bus and the ALU operand inputs, and supplies SR1/SR2 operands back into the datapath.

---
 rtl/lc3_regfile_wb_if.sv | 28 ++
 rtl/lc3_regfile_wb.sv | 73 +++++++
 tb/tb_lc3_regfile_wb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lc3_regfile_wb_if.sv
// Write-back bus bundle between the LC-3 datapath and the register file.
// slave : register file side (consumes bus/ir/load strobes, drives operands + flags)
// master: datapath/control side (drives bus/ir/load strobes, consumes operands + flags)
interface lc3_regfile_wb_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] bus_in_i;   // datapath bus value
  logic [15:0]       ir_i;       // instruction register
  logic              ld_reg_i;   // load destination register
  logic              ld_cc_i;    // load NZP
  logic              ld_ben_i;   // load BEN
  logic              drmux_i;    // 0: ir[11:9], 1: R7
  logic              sr1mux_i;   // 0: ir[11:9], 1: ir[8:6]
  logic [DATA_W-1:0] sr1_out_o;  // R[sr1], combinational
  logic [DATA_W-1:0] sr2_out_o;  // R[ir[2:0]], combinational
  logic [2:0]        nzp_out_o;  // {N,Z,P}
  logic              ben_out_o;  // branch enable

  modport slave (
    input  bus_in_i, ir_i, ld_reg_i, ld_cc_i, ld_ben_i, drmux_i, sr1mux_i,
    output sr1_out_o, sr2_out_o, nzp_out_o, ben_out_o
  );

  modport master (
    output bus_in_i, ir_i, ld_reg_i, ld_cc_i, ld_ben_i, drmux_i, sr1mux_i,
    input  sr1_out_o, sr2_out_o, nzp_out_o, ben_out_o
  );
endinterface

// File: rtl/lc3_regfile_wb.sv
// LC-3 write-back register file: eight GPRs, NZP condition codes and BEN flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears all state
//   rf   - lc3_regfile_wb_if.slave: bus value, ir, load strobes, mux selects in;
//          SR1/SR2 operands (combinational reads), NZP and BEN (registered) out
module lc3_regfile_wb #(
  parameter int unsigned DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  lc3_regfile_wb_if.slave  rf
);
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [2:0]        nzp_q, nzp_d;
  logic              ben_q, ben_d;
  logic [AW-1:0]     dr, sr1, sr2;

  // ir[15:12] and ir[5:3] are decoded elsewhere in the datapath
  logic unused_ir;
  assign unused_ir = ^{rf.ir_i[15:12], rf.ir_i[5:3]};

  // Register address decode, follows ir and mux selects combinationally
  always_comb begin
    dr  = rf.drmux_i  ? AW'(3'b111)  : rf.ir_i[11:9];
    sr1 = rf.sr1mux_i ? rf.ir_i[8:6] : rf.ir_i[11:9];
    sr2 = rf.ir_i[2:0];
  end

  // Next-state: write, condition codes and branch enable are independent
  always_comb begin
    regs_d = regs_q;
    nzp_d  = nzp_q;
    ben_d  = ben_q;
    if (rf.ld_reg_i) begin
      regs_d[dr] = rf.bus_in_i;
    end
    if (rf.ld_cc_i) begin
      if (rf.bus_in_i[DATA_W-1])      nzp_d = 3'b100;
      else if (rf.bus_in_i == '0)     nzp_d = 3'b010;
      else                            nzp_d = 3'b001;
    end
    // BEN samples the pre-edge NZP even when ld_cc fires in the same cycle
    if (rf.ld_ben_i) begin
      ben_d = (rf.ir_i[11] & nzp_q[2]) | (rf.ir_i[10] & nzp_q[1]) | (rf.ir_i[9] & nzp_q[0]);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      nzp_q <= 3'b000;
      ben_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      nzp_q  <= nzp_d;
      ben_q  <= ben_d;
    end
  end

  // Reads come straight from the registers: no write-through bypass
  assign rf.sr1_out_o = regs_q[sr1];
  assign rf.sr2_out_o = regs_q[sr2];
  assign rf.nzp_out_o = nzp_q;
  assign rf.ben_out_o = ben_q;
endmodule

// File: tb/tb_lc3_regfile_wb.sv
// Self-checking bench for lc3_regfile_wb: vector table with a scoreboard queue,
// plus hand-written async-reset sequences.
module tb_lc3_regfile_wb;
  logic clk;
  logic rst;

  lc3_regfile_wb_if #(.DATA_W(16)) rf_if ();

  lc3_regfile_wb #(.DATA_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] bus;
    logic        ld_reg;
    logic        ld_cc;
    logic        ld_ben;
    logic        drmux;
    logic        sr1mux;
    logic [15:0] e_sr1;
    logic [15:0] e_sr2;
    logic [2:0]  e_nzp;
    logic        e_ben;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [2:0]  nzp;
    logic        ben;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [15:0] mkir(input logic [2:0] d, input logic [2:0] s1,
                                       input logic [2:0] s2);
    return {4'b0001, d, s1, 3'b000, s2};
  endfunction

  task automatic add(input logic [15:0] ir, input logic [15:0] bus,
                     input logic ld_reg, input logic ld_cc, input logic ld_ben,
                     input logic drmux, input logic sr1mux,
                     input logic [15:0] e_sr1, input logic [15:0] e_sr2,
                     input logic [2:0] e_nzp, input logic e_ben);
    vec_t v;
    v.ir = ir; v.bus = bus; v.ld_reg = ld_reg; v.ld_cc = ld_cc; v.ld_ben = ld_ben;
    v.drmux = drmux; v.sr1mux = sr1mux;
    v.e_sr1 = e_sr1; v.e_sr2 = e_sr2; v.e_nzp = e_nzp; v.e_ben = e_ben;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    rf_if.ir_i     = v.ir;
    rf_if.bus_in_i = v.bus;
    rf_if.ld_reg_i = v.ld_reg;
    rf_if.ld_cc_i  = v.ld_cc;
    rf_if.ld_ben_i = v.ld_ben;
    rf_if.drmux_i  = v.drmux;
    rf_if.sr1mux_i = v.sr1mux;
  endtask

  // Drive one vector just after an edge, check pre-edge outputs at negedge, step the edge
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    drive(v);
    e.idx = idx; e.sr1 = v.e_sr1; e.sr2 = v.e_sr2; e.nzp = v.e_nzp; e.ben = v.e_ben;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d_sr1", e.idx), rf_if.sr1_out_o, e.sr1);
      chk($sformatf("v%0d_sr2", e.idx), rf_if.sr2_out_o, e.sr2);
      chk($sformatf("v%0d_nzp", e.idx), 16'(rf_if.nzp_out_o), 16'(e.nzp));
      chk($sformatf("v%0d_ben", e.idx), 16'(rf_if.ben_out_o), 16'(e.ben));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Reset sweep: all registers read zero
    for (int i = 0; i < 8; i++)
      add(mkir(3'd0, 3'(i), 3'(i)), 16'h0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 3'b000, 0);
    // Decoded writes R[d] = 1000+d; same-cycle read (sr1mux=0 on dr field) returns old
    for (int d = 0; d < 8; d++) begin
      add(mkir(3'(d), 3'd0, 3'(d)), 16'h1000 + 16'(d), 1, 0, 0, 0, 0,
          16'h0, 16'h0, 3'b000, 0);
      add(mkir(3'd0, 3'((d + 1) % 8), 3'(d)), 16'h0, 0, 0, 0, 0, 1,
          (d == 7) ? 16'h1000 : 16'h0, 16'h1000 + 16'(d), 3'b000, 0);
    end
    // Full readback sweep: no register disturbed
    for (int i = 0; i < 8; i++)
      add(mkir(3'd0, 3'(i), 3'(7 - i)), 16'h0, 0, 0, 0, 0, 1,
          16'h1000 + 16'(i), 16'h1000 + 16'(7 - i), 3'b000, 0);
    // R7 link write with ir[11:9]=2; R2 untouched
    add(mkir(3'd2, 3'd7, 3'd2), 16'h3005, 1, 0, 0, 1, 1, 16'h1007, 16'h1002, 3'b000, 0);
    add(mkir(3'd2, 3'd7, 3'd2), 16'h0,    0, 0, 0, 1, 1, 16'h3005, 16'h1002, 3'b000, 0);
    // ADD R1,R1: old value during the write cycle
    add(mkir(3'd1, 3'd1, 3'd1), 16'h1002, 1, 0, 0, 0, 1, 16'h1001, 16'h1001, 3'b000, 0);
    add(mkir(3'd1, 3'd1, 3'd1), 16'h0,    0, 0, 0, 0, 1, 16'h1002, 16'h1002, 3'b000, 0);
    // Condition codes, each visible one cycle after load; ends with NZP=010
    add(mkir(3'd0, 3'd0, 3'd0), 16'h8000, 0, 1, 0, 0, 1, 16'h1000, 16'h1000, 3'b000, 0);
    add(mkir(3'd0, 3'd0, 3'd0), 16'h0000, 0, 1, 0, 0, 1, 16'h1000, 16'h1000, 3'b100, 0);
    add(mkir(3'd0, 3'd0, 3'd0), 16'h0001, 0, 1, 0, 0, 1, 16'h1000, 16'h1000, 3'b010, 0);
    add(mkir(3'd0, 3'd0, 3'd0), 16'h7FFF, 0, 1, 0, 0, 1, 16'h1000, 16'h1000, 3'b001, 0);
    add(mkir(3'd0, 3'd0, 3'd0), 16'h0000, 0, 1, 0, 0, 1, 16'h1000, 16'h1000, 3'b001, 0);
    add(mkir(3'd0, 3'd0, 3'd0), 16'h0000, 0, 0, 0, 0, 1, 16'h1000, 16'h1000, 3'b010, 0);
    // BEN: z-branch taken, np-branch not, then ld_cc+ld_ben uses pre-edge NZP
    add(mkir(3'd2, 3'd0, 3'd0), 16'h0000, 0, 0, 1, 0, 1, 16'h1000, 16'h1000, 3'b010, 0);
    add(mkir(3'd5, 3'd0, 3'd0), 16'h0000, 0, 0, 1, 0, 1, 16'h1000, 16'h1000, 3'b010, 1);
    add(mkir(3'd4, 3'd0, 3'd0), 16'hFFFF, 0, 1, 1, 0, 1, 16'h1000, 16'h1000, 3'b010, 0);
    add(mkir(3'd4, 3'd0, 3'd0), 16'h0000, 0, 0, 0, 0, 1, 16'h1000, 16'h1000, 3'b100, 0);
    // BEN holds without ld_ben, then loads N-branch taken
    add(mkir(3'd4, 3'd0, 3'd0), 16'h0000, 0, 0, 1, 0, 1, 16'h1000, 16'h1000, 3'b100, 0);
    add(mkir(3'd4, 3'd0, 3'd0), 16'h0000, 0, 0, 0, 0, 1, 16'h1000, 16'h1000, 3'b100, 1);

    // Async reset asserted between edges
    rst = 1'b0;
    v = '{default: '0};
    drive(v);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_nzp", 16'(rf_if.nzp_out_o), 16'h0);
    chk("rst_async_ben", 16'(rf_if.ben_out_o), 16'h0);
    #18 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset during a write: R3 = BEEF, then reset while writing 1234
    add(mkir(3'd3, 3'd3, 3'd3), 16'hBEEF, 1, 0, 0, 0, 1, 16'h1003, 16'h1003, 3'b100, 1);
    run_vec(vecs[vecs.size() - 1], vecs.size() - 1);
    v = vecs[vecs.size() - 1];
    v.bus = 16'h1234;
    drive(v);
    @(negedge clk);
    chk("mid_pre_r3", rf_if.sr2_out_o, 16'hBEEF);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_sr1", rf_if.sr1_out_o, 16'h0);
    chk("mid_rst_sr2", rf_if.sr2_out_o, 16'h0);
    chk("mid_rst_nzp", 16'(rf_if.nzp_out_o), 16'h0);
    chk("mid_rst_ben", 16'(rf_if.ben_out_o), 16'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_r3", rf_if.sr2_out_o, 16'h0);
    @(negedge clk);
    rf_if.ld_reg_i = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_r3", rf_if.sr2_out_o, 16'h0);
    rf_if.ir_i = mkir(3'd0, 3'd7, 3'd0);
    #1;
    chk("post_rst_r7", rf_if.sr1_out_o, 16'h0);
    chk("post_rst_r0", rf_if.sr2_out_o, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
